// File: rtl/io_input_conditioner.sv
// io_input_conditioner
//   Conditions raw external pins for the 8-bit I/O port block. Each bit has:
//     - a multi-flop synchroniser
//     - a counter-based debouncer
//     - registered rise/fall pulses
//   Optional sticky change interrupt: define IO_IRQ_EN to add change_irq/irq_ack.
//   Every output is a flop output, so no input reaches an output combinationally.
module io_input_conditioner #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,   // 2 or more
  parameter int DEBOUNCE_CYCLES = 16   // 1 or more
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] io_input,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`ifdef IO_IRQ_EN
  ,
  output logic             change_irq,
  input  logic             irq_ack
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  // Synchroniser chain: flop to flop with nothing in between.
  // NOTE: the sync and counter arrays are reset explicitly; they are a few
  // flops, not RAM, and a reset must discard any partial debounce count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the old
      // value of the previous stage, giving a true shift register.
      sync_q[0] <= pin_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Per-bit debounce: a new level must persist DEBOUNCE_CYCLES synchronised cycles.
  always_comb begin
    // NOTE: defaults first so every path assigns every output: no latches.
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    cnt_d   = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        level_d[i] = s[i];
        cnt_d[i]   = '0;
        rise_d[i]  = s[i];
        fall_d[i]  = ~s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Debounce state, accepted level and edge pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign io_input = level_q;
  assign rise     = rise_q;
  assign fall     = fall_q;

`ifdef IO_IRQ_EN
  logic irq_q, irq_d;

  // Sticky flag: any accepted edge sets it (set beats ack), ack clears it.
  always_comb begin
    irq_d = irq_q;
    if (|(rise_q | fall_q)) irq_d = 1'b1;
    else if (irq_ack)       irq_d = 1'b0;
  end

  // Interrupt flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign change_irq = irq_q;
`endif

endmodule
